// File: rtl/key_hash_pkg.sv
// Shared definitions for the key-hash FIFO write arbiter: default key width,
// FSM state encoding and the optional statistics counter width.
package key_hash_pkg;
  localparam int KEY_W_DEF = 128;
  localparam int STAT_W    = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after last_grant,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_any
);
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(last_grant) + i) % NUM_REQ);
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
  end
endmodule

// File: rtl/key_fifo_wr_arbiter.sv
// Round-robin arbiter sharing the KeyHash FIFO write port among NUM_REQ sources.
// Define KEY_ARB_STATS_EN to add per-source accepted-beat counters (clear_stats, wr_count).
//
//   state    | meaning
//   ST_IDLE  | no grant; pick next requester round-robin, no transfer
//   ST_BURST | grant_id owns the FIFO write port until last, MAX_BURST beats, or flush
module key_fifo_wr_arbiter
  import key_hash_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int KEY_W     = KEY_W_DEF,
  parameter int MAX_BURST = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*KEY_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     flush,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [KEY_W-1:0]         fifo_din,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
`ifdef KEY_ARB_STATS_EN
  ,
  input  logic                     clear_stats,
  output logic [NUM_REQ*STAT_W-1:0] wr_count
`endif
);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  arb_state_t       state, state_nxt;
  logic [ID_W-1:0]  last_grant, gnt_id;
  logic             gnt_any, sel_valid, sel_last, accept, burst_end;
  logic [CNT_W-1:0] beat_cnt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt_id     (gnt_id),
    .gnt_any    (gnt_any)
  );

  // flush also blocks ready so the source never sees a handshake that was not written
  assign sel_valid = req_valid[grant_id];
  assign sel_last  = req_last[grant_id];
  assign accept    = (state == ST_BURST) && sel_valid && !fifo_full && !flush;
  assign burst_end = accept && (sel_last || (beat_cnt == CNT_W'(MAX_BURST - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (gnt_any && !flush) state_nxt = ST_BURST;
      ST_BURST: if (flush || burst_end) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == ST_BURST);
    fifo_wr_en = accept;
    req_ready  = '0;
    if (busy && !fifo_full && !flush) req_ready[grant_id] = 1'b1;
    fifo_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) fifo_din = req_data[i*KEY_W +: KEY_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else if (state == ST_IDLE) begin
      if (state_nxt == ST_BURST) begin
        grant_id <= gnt_id;
        beat_cnt <= '0;
      end
    end else begin
      if (accept) beat_cnt <= beat_cnt + 1'b1;
      if (state_nxt == ST_IDLE) last_grant <= grant_id;
    end
  end

`ifdef KEY_ARB_STATS_EN
  logic [STAT_W-1:0] stat_cnt [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (clear_stats)
          stat_cnt[i] <= '0;
        else if (accept && (grant_id == ID_W'(i)) && (stat_cnt[i] != '1))
          stat_cnt[i] <= stat_cnt[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign wr_count[g*STAT_W +: STAT_W] = stat_cnt[g];
  end
`endif
endmodule

// File: tb/tb_key_fifo_wr_arbiter.sv
// Scoreboard bench for key_fifo_wr_arbiter with a 16-deep FWFT FIFO model.
// Define KEY_ARB_STATS_EN to also exercise the statistics counters.
module tb_key_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int KW = 128;
  localparam int MB = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0] req_valid, req_last, req_ready;
  logic [NR*KW-1:0] req_data;
  logic flush, fifo_full, fifo_wr_en, busy;
  logic [KW-1:0] fifo_din;
  logic [1:0] grant_id;
`ifdef KEY_ARB_STATS_EN
  logic clear_stats;
  logic [NR*32-1:0] wr_count;
`endif

  key_fifo_wr_arbiter #(.NUM_REQ(NR), .KEY_W(KW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .flush(flush), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .grant_id(grant_id), .busy(busy)
`ifdef KEY_ARB_STATS_EN
    , .clear_stats(clear_stats), .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    g;
    logic [KW-1:0] d;
    int            c;
  } wr_t;

  logic [KW:0]   src_q [NR][$];
  logic [KW-1:0] exp_q [NR][$];
  logic [KW-1:0] fifo_m[$];
  logic [KW-1:0] rd_log[$];
  wr_t           wr_log[$];
  logic force_full, rd_en;
  int cyc, n_vec, n_err;
  logic s_wr, s_busy, s_full;
  logic [NR-1:0] s_ready;

  function automatic logic [KW-1:0] mk_key(input int s, input int n);
    logic [7:0] sb;
    logic [15:0] nb;
    sb = 8'(s);
    nb = 16'(n);
    return {sb, nb, $urandom(), $urandom(), $urandom(), 8'hA5};
  endfunction

  task automatic load(input int s, input int n, input int last_every);
    logic [KW-1:0] k;
    logic l;
    for (int i = 0; i < n; i++) begin
      k = mk_key(s, i);
      l = (last_every > 0) && (((i + 1) % last_every) == 0);
      src_q[s].push_back({l, k});
      exp_q[s].push_back(k);
    end
  endtask

  task automatic drive_inputs();
    logic [KW:0] f;
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        f = src_q[i][0];
        req_valid[i] = 1'b1;
        req_last[i]  = f[KW];
        req_data[i*KW +: KW] = f[KW-1:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*KW +: KW] = '0;
      end
    end
    fifo_full = force_full || (fifo_m.size() >= DEPTH);
  endtask

  // sample on negedge, let the posedge transfer happen, then update the source and FIFO models
  task automatic cycle();
    logic [NR-1:0] xfer;
    logic [KW-1:0] din;
    wr_t e;
    @(negedge clk);
    s_wr = fifo_wr_en; s_ready = req_ready; s_busy = busy; s_full = fifo_full;
    din = fifo_din;
    xfer = req_valid & req_ready;
    if (fifo_wr_en) begin
      e.g = grant_id; e.d = fifo_din; e.c = cyc;
      wr_log.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (xfer[i]) void'(src_q[i].pop_front());
    if (rd_en && fifo_m.size() > 0) rd_log.push_back(fifo_m.pop_front());
    if (s_wr && fifo_m.size() < DEPTH) fifo_m.push_back(din);
    cyc++;
    drive_inputs();
  endtask

  task automatic run_until_writes(input int n, input int budget, input string tag);
    int k = 0;
    while (wr_log.size() < n && k < budget) begin
      cycle();
      k++;
    end
    if (wr_log.size() < n) begin
      n_vec++; n_err++;
      $display("FAIL %s timeout: writes seen %0d, required %0d", tag, wr_log.size(), n);
    end
  endtask

  function automatic logic [KW-1:0] pop_exp(input int s);
    if (exp_q[s].size() == 0) return 'x;
    return exp_q[s].pop_front();
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0; force_full = 1'b0; rd_en = 1'b0;
`ifdef KEY_ARB_STATS_EN
    clear_stats = 1'b0;
`endif
    for (int i = 0; i < NR; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    fifo_m.delete(); rd_log.delete(); wr_log.delete();
    drive_inputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_inputs();
  endtask

  task automatic test_reset();
    wr_t e;
    flush = 1'b0; force_full = 1'b0; rd_en = 1'b1;
`ifdef KEY_ARB_STATS_EN
    clear_stats = 1'b0;
`endif
    load(0, 1, 1);
    drive_inputs();
    #12;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b want 0", fifo_wr_en); end
    n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant got %0d want 0", grant_id); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_inputs();
    run_until_writes(1, 10, "reset_first_write");
    if (wr_log.size() > 0) begin
      e = wr_log.pop_front();
      n_vec++; if (e.g !== 2'd0) begin n_err++; $display("FAIL reset_first_grant got %0d want 0", e.g); end
      n_vec++; if (e.d !== pop_exp(0)) begin n_err++; $display("FAIL reset_first_data got %h", e.d); end
    end
  endtask

  task automatic test_single_source();
    wr_t e;
    int prev = 0;
    do_reset();
    rd_en = 1'b1;
    load(2, 6, 0);
    drive_inputs();
    run_until_writes(6, 40, "single_src");
    for (int k = 0; k < 6 && wr_log.size() > 0; k++) begin
      e = wr_log.pop_front();
      n_vec++; if (e.g !== 2'd2) begin n_err++; $display("FAIL single_grant[%0d] got %0d want 2", k, e.g); end
      n_vec++; if (e.d !== pop_exp(2)) begin n_err++; $display("FAIL single_data[%0d] got %h", k, e.d); end
      if (k > 0) begin
        n_vec++;
        if (e.c - prev !== ((k == 4) ? 2 : 1)) begin
          n_err++; $display("FAIL single_spacing[%0d] got %0d want %0d", k, e.c - prev, (k == 4) ? 2 : 1);
        end
      end
      prev = e.c;
    end
  endtask

  task automatic test_round_robin();
    wr_t e;
    int prev = 0;
    do_reset();
    rd_en = 1'b1;
    for (int s = 0; s < NR; s++) load(s, 4, 2);
    drive_inputs();
    run_until_writes(16, 80, "round_robin");
    for (int k = 0; k < 16 && wr_log.size() > 0; k++) begin
      e = wr_log.pop_front();
      n_vec++;
      if (e.g !== 2'((k / 2) % NR)) begin n_err++; $display("FAIL rr_grant[%0d] got %0d want %0d", k, e.g, (k / 2) % NR); end
      n_vec++; if (e.d !== pop_exp(e.g)) begin n_err++; $display("FAIL rr_data[%0d] got %h", k, e.d); end
      if (k > 0) begin
        n_vec++;
        if (e.c - prev !== ((k % 2 == 1) ? 1 : 2)) begin
          n_err++; $display("FAIL rr_spacing[%0d] got %0d want %0d", k, e.c - prev, (k % 2 == 1) ? 1 : 2);
        end
      end
      prev = e.c;
    end
  endtask

  task automatic test_fifo_full();
    wr_t e;
    do_reset();
    rd_en = 1'b1;
    load(0, 4, 0);
    drive_inputs();
    run_until_writes(1, 10, "full_first");
    force_full = 1'b1;
    drive_inputs();
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_vec++; if (s_wr !== 1'b0) begin n_err++; $display("FAIL full_wr_en[%0d] got %b want 0", k, s_wr); end
      n_vec++; if (s_ready !== 4'b0) begin n_err++; $display("FAIL full_ready[%0d] got %b want 0000", k, s_ready); end
    end
    force_full = 1'b0;
    drive_inputs();
    run_until_writes(4, 20, "full_resume");
    n_vec++; if (wr_log.size() !== 4) begin n_err++; $display("FAIL full_count got %0d want 4", wr_log.size()); end
    for (int k = 0; k < 4 && wr_log.size() > 0; k++) begin
      e = wr_log.pop_front();
      n_vec++; if (e.d !== pop_exp(0)) begin n_err++; $display("FAIL full_data[%0d] got %h", k, e.d); end
    end
  endtask

  task automatic test_fill();
    logic [KW-1:0] c1[$], c3[$], seq[$];
    int turn = 1;
    int k = 0;
    do_reset();
    rd_en = 1'b0;
    load(1, 11, 11);
    load(3, 6, 6);
    drive_inputs();
    c1 = exp_q[1];
    c3 = exp_q[3];
    while (c1.size() + c3.size() > 0) begin
      for (int b = 0; b < MB; b++) begin
        if (turn == 1 && c1.size() > 0) seq.push_back(c1.pop_front());
        else if (turn == 3 && c3.size() > 0) seq.push_back(c3.pop_front());
      end
      turn = (turn == 1) ? 3 : 1;
    end
    while (fifo_m.size() < DEPTH && k < 80) begin cycle(); k++; end
    n_vec++; if (fifo_m.size() !== DEPTH) begin n_err++; $display("FAIL fill_level got %0d want %0d", fifo_m.size(), DEPTH); end
    for (int j = 0; j < 5; j++) begin
      cycle();
      n_vec++; if (s_wr !== 1'b0) begin n_err++; $display("FAIL fill_wr_while_full[%0d] got %b want 0", j, s_wr); end
    end
    n_vec++; if (s_full !== 1'b1) begin n_err++; $display("FAIL fill_full got %b want 1", s_full); end
    rd_en = 1'b1;
    k = 0;
    while (rd_log.size() < seq.size() && k < 80) begin cycle(); k++; end
    n_vec++; if (rd_log.size() !== seq.size()) begin n_err++; $display("FAIL fill_reads got %0d want %0d", rd_log.size(), seq.size()); end
    for (int j = 0; j < seq.size() && j < rd_log.size(); j++) begin
      n_vec++; if (rd_log[j] !== seq[j]) begin n_err++; $display("FAIL fill_order[%0d] got %h want %h", j, rd_log[j], seq[j]); end
    end
  endtask

  task automatic test_flush_reset();
    wr_t e;
    do_reset();
    rd_en = 1'b1;
    load(0, 4, 0);
    load(1, 3, 0);
    drive_inputs();
    run_until_writes(1, 10, "flush_first");
    if (wr_log.size() > 0) begin
      e = wr_log.pop_front();
      n_vec++; if (e.g !== 2'd0) begin n_err++; $display("FAIL flush_first_grant got %0d want 0", e.g); end
      n_vec++; if (e.d !== pop_exp(0)) begin n_err++; $display("FAIL flush_first_data got %h", e.d); end
    end
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    n_vec++; if (s_wr !== 1'b0) begin n_err++; $display("FAIL flush_wr_en got %b want 0", s_wr); end
    n_vec++; if (s_busy !== 1'b1) begin n_err++; $display("FAIL flush_busy got %b want 1", s_busy); end
    cycle();
    n_vec++; if (s_busy !== 1'b0) begin n_err++; $display("FAIL flush_idle got %b want 0", s_busy); end
    run_until_writes(2, 10, "flush_next");
    if (wr_log.size() > 1) begin
      e = wr_log.pop_front();
      n_vec++; if (e.g !== 2'd1) begin n_err++; $display("FAIL flush_next_grant got %0d want 1", e.g); end
      n_vec++; if (e.d !== pop_exp(1)) begin n_err++; $display("FAIL flush_next_data got %h", e.d); end
      e = wr_log.pop_front();
      void'(pop_exp(1));
    end
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_vec++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL midrst_wr_en got %b want 0", fifo_wr_en); end
    n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL midrst_ready got %b want 0000", req_ready); end
    n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL midrst_grant got %0d want 0", grant_id); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_inputs();
    run_until_writes(1, 10, "after_reset");
    if (wr_log.size() > 0) begin
      e = wr_log.pop_front();
      n_vec++; if (e.g !== 2'd0) begin n_err++; $display("FAIL postrst_grant got %0d want 0", e.g); end
      n_vec++; if (e.d !== pop_exp(0)) begin n_err++; $display("FAIL postrst_data got %h", e.d); end
    end
  endtask

`ifdef KEY_ARB_STATS_EN
  task automatic test_stats();
    int want [NR];
    do_reset();
    rd_en = 1'b1;
    load(0, 3, 3);
    load(2, 5, 0);
    want[0] = 3; want[1] = 0; want[2] = 5; want[3] = 0;
    drive_inputs();
    run_until_writes(8, 40, "stats");
    for (int s = 0; s < NR; s++) begin
      n_vec++;
      if (wr_count[s*32 +: 32] !== 32'(want[s])) begin
        n_err++; $display("FAIL stats_count[%0d] got %0d want %0d", s, wr_count[s*32 +: 32], want[s]);
      end
    end
    clear_stats = 1'b1;
    @(posedge clk);
    #1 clear_stats = 1'b0;
    n_vec++; if (wr_count !== '0) begin n_err++; $display("FAIL stats_clear got %h want 0", wr_count); end
  endtask
`endif

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    req_valid = '0; req_last = '0; req_data = '0;
    test_reset();
    test_single_source();
    test_round_robin();
    test_fifo_full();
    test_fill();
    test_flush_reset();
`ifdef KEY_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
